tile_unpack: RTL and testbench
==============================

# tile_unpack

Walks one 8x8 2bpp background tile in ROM storage order (16 bytes, pixel numbers 0..63) and writes each decoded pixel into a row-major 64-entry tile buffer addressed by {row, col}. It is the producer-side inverse of the tilemap's pixel_num lookup: pixel_num converts a (row, col) offset into a storage index, while this block converts a storage index back into (row, col). It sits between the tile ROM and the tilemap's per-tile line cache, and is started once per cache miss by the tilemap controller.

## Interface
- No parameters; all widths are fixed by the 2bpp 8x8 tile format and the 256-tile ROM.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_l  input  1  asynchronous, active-low reset.
- start  input  1  request to unpack a tile; sampled only in IDLE.
- tile_idx  input  8  tile number; latched when start is accepted.
- rom_en  output  1  ROM read strobe.
- rom_addr  output  12  ROM byte address, equal to {tile_q, byte_cnt}.
- rom_data  input  8  ROM read data; valid exactly 1 cycle after rom_en.
- wr_en  output  1  tile buffer write strobe.
- wr_addr  output  6  tile buffer address, equal to {row[2:0], col[2:0]}.
- wr_data  output  2  pixel colour index.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the tile has been fully written.

## Operation
- Storage mapping for pixel p[5:0]:
  - col = 7 - p[4:2].
  - row = (p[5] ? 0 : 4) + (3 - p[1:0]).
  - Check values: p=0 → (7,7); p=15 → (4,4); p=32 → (3,7).
- Byte k (0..15) holds pixels 4k..4k+3. Pixel 4k+j = {byte[j+4], byte[j]}: bits [7:4] are the high plane, bits [3:0] the low plane.
- Registers:
  - tile_q[7:0]: tile number latched at start.
  - byte_cnt[3:0]: current ROM byte.
  - pix_cnt[1:0]: pixel j within the byte.
  - byte_q[7:0]: captured ROM byte.
  - FSM state.
- FSM:
  - IDLE: if start, latch tile_idx, clear byte_cnt → REQ.
  - REQ: rom_en=1, rom_addr={tile_q, byte_cnt} → LOAD.
  - LOAD: byte_q ← rom_data, pix_cnt ← 0 → EMIT.
  - EMIT: wr_en=1, p={byte_cnt, pix_cnt}, wr_addr from the mapping, wr_data={byte_q[pix_cnt+4], byte_q[pix_cnt]}. pix_cnt increments. When pix_cnt==3: if byte_cnt==15 → DONE, else byte_cnt+1 → REQ.
  - DONE: done=1 → IDLE.
- wr_addr and wr_data are pure functions of the registered state. wr_en, rom_en and done are decoded from state only.
- start while busy is ignored; it is neither queued nor allowed to alter tile_q.
- byte_cnt does not wrap inside a tile; termination is solely at byte_cnt==15 && pix_cnt==3.

## Timing
- Reset (asynchronous, any state):
  - State returns to IDLE; all counters, tile_q and byte_q clear to 0.
  - rom_en, wr_en, busy and done are 0; rom_addr, wr_addr and wr_data are 0.
  - An in-progress tile is abandoned with no done pulse. Buffer entries already written stay written.
- Cycle numbering, with start high at edge 0:
  - REQ for byte k occupies cycle 1+6k; LOAD occupies 2+6k; EMIT occupies 3+6k..6+6k.
  - The final write occurs in cycle 96; done is high in cycle 97; IDLE is reached in cycle 98.
  - start may be accepted at the edge that ends cycle 97, so back-to-back tiles take 97 cycles each.
- busy rises in cycle 1 and falls after cycle 97.
- Exactly 64 writes and 16 ROM reads occur per tile. Each buffer address is written exactly once.
- When start and rst_l deassertion coincide, reset wins and no tile starts.

## Test plan
- Reset check: assert rst_l=0 mid-EMIT → all outputs 0 immediately, no done pulse. Then deassert and start tile 0x05 → first rom_addr = 0x050.
- Byte decode: tile 0x01 with byte0=0x0F and all other bytes 0 → writes 1 to addresses 63, 55, 47, 39 (cycles 3-6), all other writes 0.
- Mapping check: byte3=0x80 → pixel 15 writes 2 to addr 36. byte8=0x11 → pixel 32 writes 3 to addr 31.
- Coverage and count: random ROM contents → exactly 64 wr_en pulses and every address 0..63 hit once; 16 rom_en pulses; done in cycle 97.
- Busy handling: pulse start with tile 0x22 during busy → ignored, tile_q unchanged. Start at the edge ending the done cycle → the next tile's REQ occurs in the following cycle.
- Golden model: for all 64 (row, col) pairs, buffer contents match the pixel_num forward mapping applied to ROM bytes, across 3 random tiles.

Source files
------------

// File: rtl/tile_unpack_if.sv
// Bus between the tile unpacker, its controller, the tile ROM and the line-cache tile buffer.
interface tile_unpack_if;
  logic        start;
  logic [7:0]  tile_idx;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [1:0]  wr_data;
  logic        busy;
  logic        done;

  modport master (
    output start, tile_idx, rom_data,
    input  rom_en, rom_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, tile_idx, rom_data,
    output rom_en, rom_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/tile_unpack.sv
// Walks one 8x8 2bpp tile in ROM storage order and writes each pixel into a
// row-major {row, col} tile buffer.
module tile_unpack (
  input  logic          clk,
  input  logic          rst_l,
  tile_unpack_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_tile_q;
  logic [7:0]  r_byte_q;
  logic [3:0]  r_byte_cnt;
  logic [1:0]  r_pix_cnt;
  logic        w_accept;
  logic        w_emit;
  logic        w_last;

  assign w_last = (r_pix_cnt == 2'd3);

  // DONE also accepts start so back-to-back tiles cost 97 cycles each.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_emit     = 1'b0;
    bus.rom_en = 1'b0;
    bus.wr_en  = 1'b0;
    bus.done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = bus.start;
        if (bus.start) w_next = S_REQ;
      end
      S_REQ: begin
        bus.rom_en = 1'b1;
        w_next     = S_LOAD;
      end
      S_LOAD: w_next = S_EMIT;
      S_EMIT: begin
        bus.wr_en = 1'b1;
        w_emit    = 1'b1;
        if (w_last) w_next = (r_byte_cnt == 4'hF) ? S_DONE : S_REQ;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_accept = bus.start;
        w_next   = bus.start ? S_REQ : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state    <= S_IDLE;
      r_tile_q   <= 8'd0;
      r_byte_q   <= 8'd0;
      r_byte_cnt <= 4'd0;
      r_pix_cnt  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_tile_q   <= bus.tile_idx;
        r_byte_cnt <= 4'd0;
      end
      if (r_state == S_LOAD) begin
        r_byte_q  <= bus.rom_data;
        r_pix_cnt <= 2'd0;
      end
      if (w_emit) begin
        r_pix_cnt <= r_pix_cnt + 2'd1;
        if (w_last && r_byte_cnt != 4'hF) r_byte_cnt <= r_byte_cnt + 4'd1;
      end
    end
  end

  // p = {byte_cnt, pix_cnt}: row = {~p[5], ~p[1:0]}, col = ~p[4:2].
  // Gated by EMIT so the write bus idles at zero.
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.rom_addr = {r_tile_q, r_byte_cnt};
  assign bus.wr_addr  = w_emit ? {~r_byte_cnt[3], ~r_pix_cnt, ~r_byte_cnt[2:0]} : 6'd0;
  assign bus.wr_data  = w_emit ? {r_byte_q[{1'b1, r_pix_cnt}], r_byte_q[{1'b0, r_pix_cnt}]} : 2'd0;

endmodule

// File: tb/tb_tile_unpack.sv
// Self-checking bench for tile_unpack: directed vector table, scoreboard of expected writes,
// and hand sequences for reset, busy/back-to-back and golden-buffer comparison.
module tb_tile_unpack;

  logic clk;
  logic rst_l;
  tile_unpack_if bus ();

  tile_unpack dut (.clk(clk), .rst_l(rst_l), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tile;
    logic [3:0] bidx;
    logic [7:0] bval;
    logic [5:0] addr;
    logic [1:0] data;
  } vec_t;

  typedef struct {
    logic [5:0] a;
    logic [1:0] d;
  } wr_t;

  logic [7:0] rom [0:4095];
  logic [5:0] inv [0:63];
  logic [1:0] tbuf [0:63];
  int         hits [0:63];
  int         hits0 [0:63];
  wr_t        sbq [$];
  vec_t       vecs [6];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int n_wr     = 0;
  int n_rd     = 0;
  int n_done   = 0;
  int done_cyc = 0;
  int bad_tile = 0;
  logic [7:0] cur_tile = 8'd0;
  int c0, rd0, wr0, dn0, bt0;

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Forward pixel_num lookup: (row, col) -> storage index.
  function automatic logic [5:0] pixnum(input int r, input int c);
    logic [5:0] p;
    p[5]   = (r < 4);
    p[4:2] = 3'(7 - c);
    p[1:0] = 2'(3 - (r % 4));
    return p;
  endfunction

  function automatic logic [1:0] pixval(input logic [7:0] t, input logic [5:0] p);
    logic [7:0] b;
    int j;
    b = rom[{t, p[5:2]}];
    j = int'(p[1:0]);
    return {b[j + 4], b[j]};
  endfunction

  always @(posedge clk)
    if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];

  always @(negedge clk) begin
    if (!rst_l) sbq.delete();
    else begin
      cyc++;
      if (bus.rom_en) begin
        n_rd++;
        if (bus.rom_addr[11:4] != cur_tile) bad_tile++;
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.wr_en) begin
        n_wr++;
        hits[bus.wr_addr]++;
        tbuf[bus.wr_addr] = bus.wr_data;
        if (sbq.size() == 0) begin
          tot_cnt++;
          $display("FAIL sb_extra: write addr %0d data %0d with no expected entry",
                   bus.wr_addr, bus.wr_data);
        end else begin
          wr_t e;
          e = sbq.pop_front();
          chk("sb_write", int'({bus.wr_addr, bus.wr_data}), int'({e.a, e.d}));
        end
      end
    end
  end

  // Called #1 after a negedge; start is sampled at the following posedge (edge 0).
  task automatic begin_tile(input logic [7:0] t);
    wr_t e;
    for (int p = 0; p < 64; p++) begin
      e.a = inv[p];
      e.d = pixval(t, 6'(p));
      sbq.push_back(e);
    end
    cur_tile = t;
    rd0 = n_rd; wr0 = n_wr; dn0 = n_done; bt0 = bad_tile;
    hits0 = hits;
    bus.tile_idx = t;
    bus.start    = 1'b1;
    @(posedge clk);
    c0 = cyc;
    #1 bus.start = 1'b0;
  endtask

  // Returns #1 after the negedge inside the done cycle.
  task automatic finish_tile(input string nm);
    int bad;
    for (int i = 0; i < 200 && n_done == dn0; i++) begin
      @(negedge clk);
      #1;
    end
    chk({nm, "_done_seen"}, n_done - dn0, 1);
    chk({nm, "_done_cycle"}, done_cyc - c0, 97);
    chk({nm, "_rom_reads"}, n_rd - rd0, 16);
    chk({nm, "_writes"}, n_wr - wr0, 64);
    chk({nm, "_rom_tile"}, bad_tile - bt0, 0);
    chk({nm, "_sb_left"}, sbq.size(), 0);
    bad = 0;
    for (int a = 0; a < 64; a++) if (hits[a] - hits0[a] != 1) bad++;
    chk({nm, "_coverage"}, bad, 0);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_busy"}, int'(bus.busy), 0);
    chk({nm, "_rom_en"}, int'(bus.rom_en), 0);
    chk({nm, "_wr_en"}, int'(bus.wr_en), 0);
    chk({nm, "_done"}, int'(bus.done), 0);
    chk({nm, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({nm, "_wr_addr"}, int'(bus.wr_addr), 0);
    chk({nm, "_wr_data"}, int'(bus.wr_data), 0);
  endtask

  initial begin
    vecs[0] = '{tile: 8'h01, bidx: 4'd0,  bval: 8'h0F, addr: 6'd63, data: 2'd1};
    vecs[1] = '{tile: 8'h01, bidx: 4'd0,  bval: 8'h0F, addr: 6'd39, data: 2'd1};
    vecs[2] = '{tile: 8'h02, bidx: 4'd3,  bval: 8'h80, addr: 6'd36, data: 2'd2};
    vecs[3] = '{tile: 8'h03, bidx: 4'd8,  bval: 8'h11, addr: 6'd31, data: 2'd3};
    vecs[4] = '{tile: 8'h04, bidx: 4'd15, bval: 8'hF0, addr: 6'd24, data: 2'd2};
    vecs[5] = '{tile: 8'h06, bidx: 4'd7,  bval: 8'h01, addr: 6'd56, data: 2'd1};

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) inv[pixnum(r, c)] = 6'(r * 8 + c);
    for (int a = 0; a < 4096; a++) rom[a] = 8'($urandom);
    for (int a = 0; a < 64; a++) begin hits[a] = 0; tbuf[a] = 2'd0; end

    rst_l = 1'b0;
    bus.start = 1'b0;
    bus.tile_idx = 8'd0;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    rst_l = 1'b1;
    @(negedge clk); #1;

    // Directed decode/mapping vectors: one nonzero byte per tile
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 16; k++) rom[{vecs[v].tile, 4'(k)}] = 8'd0;
      rom[{vecs[v].tile, vecs[v].bidx}] = vecs[v].bval;
      begin_tile(vecs[v].tile);
      finish_tile($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_buf", v), int'(tbuf[vecs[v].addr]), int'(vecs[v].data));
      @(negedge clk); #1;
    end

    // Asynchronous reset in the middle of EMIT
    begin_tile(8'h10);
    for (int i = 0; i < 50 && !bus.wr_en; i++) begin @(negedge clk); #1; end
    chk("rst_reached_emit", int'(bus.wr_en), 1);
    dn0 = n_done;
    rst_l = 1'b0;
    #1 check_idle_outputs("rst_mid");
    repeat (3) @(negedge clk);
    #1 rst_l = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("rst_no_done", n_done - dn0, 0);
    begin_tile(8'h05);
    @(negedge clk); #1;
    chk("rst_first_rom_en", int'(bus.rom_en), 1);
    chk("rst_first_rom_addr", int'(bus.rom_addr), 'h050);
    finish_tile("after_rst");
    @(negedge clk); #1;

    // start while busy is ignored
    begin_tile(8'h33);
    repeat (10) @(negedge clk);
    #1 bus.tile_idx = 8'h22;
    bus.start = 1'b1;
    @(negedge clk);
    #1 bus.start = 1'b0;
    finish_tile("busy_ign");
    @(negedge clk); #1;
    chk("busy_fall", int'(bus.busy), 0);

    // Back-to-back: start accepted at the edge ending the done cycle
    begin_tile(8'h41);
    finish_tile("b2b_a");
    begin_tile(8'h42);
    @(negedge clk); #1;
    chk("b2b_req_en", int'(bus.rom_en), 1);
    chk("b2b_req_addr", int'(bus.rom_addr), 'h420);
    finish_tile("b2b_b");
    @(negedge clk); #1;

    // Golden buffer compare over three random tiles
    for (int g = 0; g < 3; g++) begin
      logic [7:0] t;
      t = 8'($urandom_range(8'h80, 8'hFF));
      begin_tile(t);
      finish_tile($sformatf("gold%0d", g));
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          chk($sformatf("gold%0d_r%0dc%0d", g, r, c),
              int'(tbuf[r * 8 + c]), int'(pixval(t, pixnum(r, c))));
      @(negedge clk); #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
